// File: rtl/word_feed_fifo_pkg.sv
// rtl/word_feed_fifo_pkg.sv - shared types and defaults for the word feeder
//
// Purpose: hand-off FSM encoding and default parameter values shared by the
//          feeder top level and its FIFO.
// Contents: feed_state_t (FEED_IDLE=0, FEED_WAIT_START=1, FEED_WAIT_DONE=2),
//           DEF_LOAD_WIDTH, DEF_DEPTH, DEF_START_TMO.
package word_feed_fifo_pkg;

  localparam int DEF_LOAD_WIDTH = 32;
  localparam int DEF_DEPTH      = 4;
  localparam int DEF_START_TMO  = 4;

  typedef enum logic [1:0] {
    FEED_IDLE       = 2'd0,
    FEED_WAIT_START = 2'd1,
    FEED_WAIT_DONE  = 2'd2
  } feed_state_t;

endpackage

// File: rtl/word_fifo.sv
// rtl/word_fifo.sv - synchronous first-word-fall-through FIFO
//
// Purpose: stores WIDTH-bit words; rd_data always shows the oldest word.
// Ports:
//   clk      in   rising-edge clock
//   reset    in   asynchronous active-low reset (pointers and count only)
//   wr_en    in   store wr_data when not full
//   wr_data  in   WIDTH-bit word to store
//   rd_en    in   drop the head word when not empty
//   rd_data  out  head word (valid when !empty)
//   count    out  words stored, $clog2(DEPTH)+1 bits
//   full     out  count == DEPTH
//   empty    out  count == 0
module word_fifo
  import word_feed_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_LOAD_WIDTH,
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_wr;
  logic             w_do_rd;

  // Fullness is judged on the current count, so a write into a full FIFO is
  // dropped even when a read frees a slot on the same edge.
  assign w_do_wr = wr_en && (r_count != FULL_CNT);
  assign w_do_rd = rd_en && (r_count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_wr, w_do_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage is not reset; stale contents are never visible because the
  // pointers and count are.
  always_ff @(posedge clk) begin
    if (w_do_wr) r_mem[r_wr_ptr] <= wr_data;
  end

  assign rd_data = r_mem[r_rd_ptr];
  assign count   = r_count;
  assign full    = (r_count == FULL_CNT);
  assign empty   = (r_count == '0);

endmodule

// File: rtl/word_feed_fifo.sv
// rtl/word_feed_fifo.sv - buffered word feeder for the parallel-load byte shifter
//
// Purpose: queues producer words and hands them one at a time to the shifter,
//          waiting for its busy to rise and fall between hand-offs.
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-low reset
//   wr_data    in   LOAD_WIDTH word to enqueue
//   wr_en      in   enqueue wr_data this cycle
//   full       out  FIFO holds DEPTH words
//   count      out  words currently stored
//   overflow   out  sticky: a write was dropped while full
//   sh_busy    in   busy from the shifter
//   sh_din     out  word presented to the shifter
//   sh_enable  out  one-cycle load strobe
//   tmo_err    out  sticky: shifter never went busy within START_TMO cycles
module word_feed_fifo
  import word_feed_fifo_pkg::*;
#(
  parameter int LOAD_WIDTH = DEF_LOAD_WIDTH,
  parameter int DEPTH      = DEF_DEPTH,
  parameter int START_TMO  = DEF_START_TMO
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [LOAD_WIDTH-1:0]   wr_data,
  input  logic                    wr_en,
  output logic                    full,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow,
  input  logic                    sh_busy,
  output logic [LOAD_WIDTH-1:0]   sh_din,
  output logic                    sh_enable,
  output logic                    tmo_err
);

  localparam int TW = (START_TMO > 1) ? $clog2(START_TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(START_TMO - 1);

  feed_state_t           r_state;
  feed_state_t           w_state_n;
  logic [TW-1:0]         r_tmo_cnt;
  logic [TW-1:0]         w_tmo_cnt_n;
  logic                  r_sh_enable;
  logic                  w_sh_enable_n;
  logic [LOAD_WIDTH-1:0] r_sh_din;
  logic [LOAD_WIDTH-1:0] w_sh_din_n;
  logic                  r_tmo_err;
  logic                  w_tmo_err_n;
  logic                  r_overflow;
  logic                  w_pop;
  logic [LOAD_WIDTH-1:0] w_head;
  logic                  w_full;
  logic                  w_empty;

  word_fifo #(
    .WIDTH (LOAD_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .rd_en   (w_pop),
    .rd_data (w_head),
    .count   (count),
    .full    (w_full),
    .empty   (w_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= FEED_IDLE;
      r_tmo_cnt   <= '0;
      r_sh_enable <= 1'b0;
      r_sh_din    <= '0;
      r_tmo_err   <= 1'b0;
    end else begin
      r_state     <= w_state_n;
      r_tmo_cnt   <= w_tmo_cnt_n;
      r_sh_enable <= w_sh_enable_n;
      r_sh_din    <= w_sh_din_n;
      r_tmo_err   <= w_tmo_err_n;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overflow <= 1'b0;
    end else if (wr_en && w_full) begin
      r_overflow <= 1'b1;
    end
  end

  always_comb begin
    w_state_n     = r_state;
    w_tmo_cnt_n   = r_tmo_cnt;
    w_sh_enable_n = 1'b0;
    w_sh_din_n    = r_sh_din;
    w_tmo_err_n   = r_tmo_err;
    w_pop         = 1'b0;
    case (r_state)
      FEED_IDLE: begin
        // A shifter still busy from someone else's load blocks the hand-off.
        if (!w_empty && !sh_busy) begin
          w_sh_enable_n = 1'b1;
          w_sh_din_n    = w_head;
          w_pop         = 1'b1;
          w_tmo_cnt_n   = '0;
          w_state_n     = FEED_WAIT_START;
        end
      end
      FEED_WAIT_START: begin
        if (sh_busy) begin
          w_state_n = FEED_WAIT_DONE;
        end else if (r_tmo_cnt == TMO_LAST) begin
          w_tmo_err_n = 1'b1;
          w_state_n   = FEED_IDLE;
        end else begin
          w_tmo_cnt_n = r_tmo_cnt + 1'b1;
        end
      end
      FEED_WAIT_DONE: begin
        if (!sh_busy) w_state_n = FEED_IDLE;
      end
      default: w_state_n = FEED_IDLE;
    endcase
  end

  assign full      = w_full;
  assign overflow  = r_overflow;
  assign sh_din    = r_sh_din;
  assign sh_enable = r_sh_enable;
  assign tmo_err   = r_tmo_err;

endmodule

// File: tb/tb_word_feed_fifo.sv
// tb/tb_word_feed_fifo.sv - self-checking bench for word_feed_fifo
module tb_word_feed_fifo;

  localparam int LW        = 32;
  localparam int DEPTH     = 4;
  localparam int START_TMO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [LW-1:0] wr_data;
  logic          wr_en;
  logic          full;
  logic [2:0]    count;
  logic          overflow;
  logic          sh_busy;
  logic [LW-1:0] sh_din;
  logic          sh_enable;
  logic          tmo_err;

  word_feed_fifo #(
    .LOAD_WIDTH (LW),
    .DEPTH      (DEPTH),
    .START_TMO  (START_TMO)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .wr_data   (wr_data),
    .wr_en     (wr_en),
    .full      (full),
    .count     (count),
    .overflow  (overflow),
    .sh_busy   (sh_busy),
    .sh_din    (sh_din),
    .sh_enable (sh_enable),
    .tmo_err   (tmo_err)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int tb_cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, tb_cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    tb_cyc++;
  end

  // Bench shifter: 0 = loads a word, goes busy 2 cycles after sh_enable for
  // 4 cycles; 1 = busy held high; 2 = busy held low.
  int sh_mode = 2;
  initial begin
    int sh_t;
    sh_t    = 0;
    sh_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) sh_t = 0;
      case (sh_mode)
        0: begin
          if (sh_enable) sh_t = 1;
          else if (sh_t > 0) sh_t++;
          sh_busy = (sh_t >= 2 && sh_t <= 5);
          if (sh_t > 5) sh_t = 0;
        end
        1: sh_busy = 1'b1;
        default: sh_busy = 1'b0;
      endcase
    end
  end

  // Behavioural model: a word queue plus the hand-off rule "issue only when
  // free and the shifter is idle; become free when busy has risen and fallen,
  // or when START_TMO edges pass after the strobe without busy".
  logic [LW-1:0] q[$];
  logic          m_en, m_over, m_tmo;
  logic [LW-1:0] m_din;
  bit            engaged, seen_busy;
  int            m_cyc, en_cyc;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      q.delete();
      m_en = 0; m_over = 0; m_tmo = 0; m_din = '0;
      engaged = 0; seen_busy = 0; m_cyc = 0; en_cyc = 0;
    end else begin
      bit was_full;
      m_cyc++;
      was_full = (q.size() == DEPTH);
      m_en = 0;
      if (!engaged) begin
        if (q.size() != 0 && !sh_busy) begin
          m_din = q.pop_front();
          m_en = 1; engaged = 1; seen_busy = 0; en_cyc = m_cyc;
        end
      end else if (!seen_busy) begin
        if (sh_busy) seen_busy = 1;
        else if (m_cyc - en_cyc == START_TMO) begin
          m_tmo = 1; engaged = 0;
        end
      end else if (!sh_busy) begin
        engaged = 0;
      end
      if (wr_en) begin
        if (was_full) m_over = 1;
        else q.push_back(wr_data);
      end
    end
  end

  logic [LW-1:0] pulse_din[$];
  int            pulse_cyc[$];
  int            tmo_cyc  = -1;
  logic          tmo_prev = 1'b0;
  int            peak     = 0;

  always @(negedge clk) begin
    chk("sh_enable", 32'(sh_enable), 32'(m_en));
    chk("sh_din",    sh_din,         m_din);
    chk("count",     32'(count),     32'(q.size()));
    chk("full",      32'(full),      32'(q.size() == DEPTH));
    chk("overflow",  32'(overflow),  32'(m_over));
    chk("tmo_err",   32'(tmo_err),   32'(m_tmo));
    if (sh_enable) begin
      pulse_din.push_back(sh_din);
      pulse_cyc.push_back(tb_cyc);
    end
    if (tmo_err && !tmo_prev) tmo_cyc = tb_cyc;
    tmo_prev = tmo_err;
    if (int'(count) > peak) peak = int'(count);
  end

  task automatic put(input logic [LW-1:0] d);
    wr_en   = 1'b1;
    wr_data = d;
    @(negedge clk);
    wr_en   = 1'b0;
  endtask

  task automatic wait_pulses(input string name, input int n, input int budget);
    int k;
    k = 0;
    while (pulse_din.size() < n && k < budget) begin
      @(negedge clk); #1;
      k++;
    end
    chk(name, 32'(pulse_din.size()), 32'(n));
  endtask

  task automatic clear_log();
    pulse_din.delete();
    pulse_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk); #2 reset = 1'b0;
    @(negedge clk); #2 reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int w_cyc;
    logic [LW-1:0] words3[3];
    reset = 1'b0; wr_en = 1'b0; wr_data = '0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b1;

    // 1: reset mid-hand-off
    @(negedge clk);
    sh_mode = 0;
    put(32'h0BADF00D);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("rst_sh_enable", 32'(sh_enable), 32'h0);
    chk("rst_sh_din",    sh_din,         32'h0);
    chk("rst_count",     32'(count),     32'h0);
    chk("rst_full",      32'(full),      32'h0);
    chk("rst_overflow",  32'(overflow),  32'h0);
    chk("rst_tmo_err",   32'(tmo_err),   32'h0);
    #2 reset = 1'b1;
    clear_log();
    repeat (10) @(negedge clk);
    #1 chk("rst_no_pulses", 32'(pulse_din.size()), 32'h0);

    // 2: single word, latency 2 edges
    clear_log();
    w_cyc = tb_cyc;
    put(32'hDEADBEEF);
    wait_pulses("t2_pulses", 1, 20);
    if (pulse_cyc.size() > 0) begin
      chk("t2_latency", 32'(pulse_cyc[0] - w_cyc), 32'd2);
      chk("t2_word",    pulse_din[0],              32'hDEADBEEF);
    end
    repeat (3) @(negedge clk);
    chk("t2_din_hold", sh_din,     32'hDEADBEEF);
    chk("t2_count",    32'(count), 32'h0);
    repeat (10) @(negedge clk);

    // 3: three back-to-back words
    clear_log();
    peak = 0;
    words3[0] = 32'h11223344; words3[1] = 32'h55667788; words3[2] = 32'h99AABBCC;
    for (int i = 0; i < 3; i++) put(words3[i]);
    wait_pulses("t3_pulses", 3, 100);
    for (int i = 0; i < 3 && i < pulse_din.size(); i++)
      chk($sformatf("t3_word%0d", i), pulse_din[i], words3[i]);
    chk("t3_peak_ok", 32'(peak == 2 || peak == 3), 32'h1);
    chk("t3_tmo_err", 32'(tmo_err), 32'h0);
    repeat (15) @(negedge clk);

    // 4: busy held, overfill
    clear_log();
    sh_mode = 1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) put(32'hA0000000 + 32'(i));
    @(negedge clk);
    chk("t4_full",     32'(full),     32'h1);
    chk("t4_count",    32'(count),    32'd4);
    chk("t4_overflow", 32'(overflow), 32'h1);
    #1 chk("t4_no_pulses", 32'(pulse_din.size()), 32'h0);

    // 5: shifter never goes busy -> timeout, then back in idle
    sh_mode = 2;
    do_reset();
    clear_log();
    tmo_cyc = -1;
    put(32'hA5A5A5A5);
    wait_pulses("t5_pulses", 1, 20);
    repeat (START_TMO + 2) @(negedge clk);
    chk("t5_tmo_err", 32'(tmo_err), 32'h1);
    if (pulse_cyc.size() > 0) chk("t5_tmo_delay", 32'(tmo_cyc - pulse_cyc[0]), 32'(START_TMO));
    clear_log();
    w_cyc = tb_cyc;
    put(32'h5A5A5A5A);
    wait_pulses("t5_idle_pulse", 1, 20);
    if (pulse_cyc.size() > 0) chk("t5_idle_latency", 32'(pulse_cyc[0] - w_cyc), 32'd2);
    repeat (8) @(negedge clk);

    // 6: reset in WAIT_DONE with two words queued
    do_reset();
    sh_mode = 0;
    clear_log();
    put(32'hC0DE0001); put(32'hC0DE0002); put(32'hC0DE0003);
    repeat (2) @(negedge clk);
    chk("t6_count_before", 32'(count), 32'd2);
    #2 reset = 1'b0;
    @(negedge clk);
    chk("t6_count",     32'(count),     32'h0);
    chk("t6_sh_enable", 32'(sh_enable), 32'h0);
    #2 reset = 1'b1;
    sh_mode = 2;
    clear_log();
    repeat (10) @(negedge clk);
    #1 chk("t6_no_pulses", 32'(pulse_din.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

endmodule
